// File: rtl/sr_reg_bank.sv
// Bank of WIDTH independent set/reset flags with a configurable S=R=1 policy,
// registered edge pulses, sticky per-channel conflict flags and a saturating conflict counter.
module sr_reg_bank #(
  parameter int                   WIDTH         = 8,
  parameter int                   CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0]     RESET_VAL     = '0,
  parameter int                   CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] conf_now;
  logic             conf_any;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic resolve(input logic cur, input logic sv, input logic rv);
    logic nxt;
    nxt = cur;
    case ({sv, rv})
      2'b01:   nxt = 1'b0;
      2'b10:   nxt = 1'b1;
      2'b11: begin
        case (CONFLICT_MODE)
          1:       nxt = 1'b1;
          2:       nxt = 1'b0;
          3:       nxt = ~cur;
          default: nxt = cur;
        endcase
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // next-state evaluation: clr beats en; conflicts only count on real updates
  always_comb begin
    q_next   = q;
    conf_now = '0;
    if (clr) begin
      q_next = RESET_VAL;
    end else if (en) begin
      conf_now = s & r;
      for (int i = 0; i < WIDTH; i++) begin
        q_next[i] = resolve(q[i], s[i], r[i]);
      end
    end
  end

  assign conf_any = |conf_now;

  // state, pulse and conflict registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q            <= RESET_VAL;
      q_rise       <= '0;
      q_fall       <= '0;
      conflict     <= '0;
      conflict_cnt <= '0;
    end else begin
      q      <= q_next;
      q_rise <= ~q & q_next;
      q_fall <= q & ~q_next;
      if (err_clr) begin
        conflict     <= conf_now;
        conflict_cnt <= conf_any ? CNT_ONE : '0;
      end else begin
        conflict <= conflict | conf_now;
        if (conf_any) begin
          conflict_cnt <= sat_inc(conflict_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench: four conflict-mode instances (CNT_W=3) and one RESET_VAL=1010 instance share stimulus.
module tb_sr_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n, en, clr, err_clr;
  logic [3:0] s, r;

  logic [3:0] d0_q, d0_rise, d0_fall, d0_conf;
  logic [3:0] d1_q, d1_rise, d1_fall, d1_conf;
  logic [3:0] d2_q, d2_rise, d2_fall, d2_conf;
  logic [3:0] d3_q, d3_rise, d3_fall, d3_conf;
  logic [3:0] dr_q, dr_rise, dr_fall, dr_conf;
  logic [2:0] d0_cnt, d1_cnt, d2_cnt, d3_cnt;
  logic [7:0] dr_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(0), .RESET_VAL(4'b0000), .CNT_W(3)) u_d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r), .err_clr(err_clr),
    .q(d0_q), .q_rise(d0_rise), .q_fall(d0_fall), .conflict(d0_conf), .conflict_cnt(d0_cnt));
  sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(1), .RESET_VAL(4'b0000), .CNT_W(3)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r), .err_clr(err_clr),
    .q(d1_q), .q_rise(d1_rise), .q_fall(d1_fall), .conflict(d1_conf), .conflict_cnt(d1_cnt));
  sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(2), .RESET_VAL(4'b0000), .CNT_W(3)) u_d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r), .err_clr(err_clr),
    .q(d2_q), .q_rise(d2_rise), .q_fall(d2_fall), .conflict(d2_conf), .conflict_cnt(d2_cnt));
  sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(3), .RESET_VAL(4'b0000), .CNT_W(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r), .err_clr(err_clr),
    .q(d3_q), .q_rise(d3_rise), .q_fall(d3_fall), .conflict(d3_conf), .conflict_cnt(d3_cnt));
  sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(0), .RESET_VAL(4'b1010), .CNT_W(8)) u_dr (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r), .err_clr(err_clr),
    .q(dr_q), .q_rise(dr_rise), .q_fall(dr_fall), .conflict(dr_conf), .conflict_cnt(dr_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; err_clr = 1'b0; s = 4'hF; r = 4'hF;
    tick(); tick();
    chk("rst_q",    32'(dr_q),    32'h0000_000A);
    chk("rst_rise", 32'(dr_rise), 32'h0);
    chk("rst_fall", 32'(dr_fall), 32'h0);
    chk("rst_conf", 32'(dr_conf), 32'h0);
    chk("rst_cnt",  32'(dr_cnt),  32'h0);
    chk("rst_q_m3", 32'(d3_q),    32'h0);

    // first post-reset edge
    rst_n = 1'b1; s = 4'b0101; r = 4'b0000;
    tick();
    chk("rel_q",    32'(dr_q),    32'hF);
    chk("rel_rise", 32'(dr_rise), 32'h5);
    chk("rel_fall", 32'(dr_fall), 32'h0);
    chk("rel_q_m0", 32'(d0_q),    32'h5);

    // mode sweep on channel 0 starting from q[0]=0
    s = 4'b0000; r = 4'b0001;
    tick();
    chk("ch0_clr_q",    32'(d0_q),    32'h4);
    chk("ch0_clr_fall", 32'(d0_fall), 32'h1);
    s = 4'b0001; r = 4'b0001;
    tick();
    chk("m0_q0", 32'(d0_q), 32'h4);
    chk("m1_q0", 32'(d1_q), 32'h5);
    chk("m2_q0", 32'(d2_q), 32'h4);
    chk("m3_q0", 32'(d3_q), 32'h5);
    chk("m_conf", 32'(d2_conf), 32'h1);
    chk("m_cnt1", 32'(d1_cnt),  32'h1);

    // mode sweep starting from q[0]=1
    s = 4'b0001; r = 4'b0000;
    tick();
    chk("set_rise_m0", 32'(d0_rise), 32'h1);
    chk("set_cnt_hold", 32'(d0_cnt), 32'h1);
    s = 4'b0001; r = 4'b0001;
    tick();
    chk("m0_q1", 32'(d0_q), 32'h5);
    chk("m1_q1", 32'(d1_q), 32'h5);
    chk("m2_q1", 32'(d2_q), 32'h4);
    chk("m3_q1", 32'(d3_q), 32'h4);
    chk("m3_fall", 32'(d3_fall), 32'h1);
    chk("m_cnt2", 32'(d3_cnt), 32'h2);
    tick();
    chk("m3_toggle", 32'(d3_q),   32'h5);
    chk("m3_cnt3",   32'(d3_cnt), 32'h3);
    chk("m2_again",  32'(d2_q),   32'h4);

    // enable gating
    en = 1'b0; s = 4'hF; r = 4'h0;
    tick();
    chk("gate_rise", 32'(d0_rise), 32'h0);
    tick(); tick();
    chk("gate_q",    32'(d0_q),    32'h5);
    chk("gate_fall", 32'(d0_fall), 32'h0);
    chk("gate_conf", 32'(d0_conf), 32'h1);
    chk("gate_cnt",  32'(d0_cnt),  32'h3);
    en = 1'b1;
    tick();
    chk("en_q",     32'(d0_q),    32'hF);
    chk("en_rise",  32'(d0_rise), 32'hA);
    chk("en_rise2", 32'(d2_rise), 32'hB);

    // clr beats en and records no conflict
    clr = 1'b1; s = 4'hF; r = 4'hF;
    tick();
    chk("clr_q",     32'(d0_q),    32'h0);
    chk("clr_fall",  32'(d0_fall), 32'hF);
    chk("clr_conf",  32'(d0_conf), 32'h1);
    chk("clr_cnt",   32'(d0_cnt),  32'h3);
    chk("clr_q_rv",  32'(dr_q),    32'hA);
    chk("clr_fall_rv", 32'(dr_fall), 32'h5);

    // counter saturation
    clr = 1'b0; err_clr = 1'b1; s = 4'h0; r = 4'h0;
    tick();
    chk("eclr_conf", 32'(d0_conf), 32'h0);
    chk("eclr_cnt",  32'(d0_cnt),  32'h0);
    err_clr = 1'b0; s = 4'b0010; r = 4'b0010;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("sat_cnt_%0d", k), 32'(d0_cnt), (k > 7) ? 32'd7 : 32'(k));
    end
    chk("sat_conf",   32'(d0_conf), 32'h2);
    chk("wide_cnt10", 32'(dr_cnt),  32'd10);

    // err_clr colliding with a new conflict
    err_clr = 1'b1; s = 4'h0; r = 4'h0;
    tick();
    err_clr = 1'b0; s = 4'b0001; r = 4'b0001;
    tick(); tick(); tick();
    s = 4'b0010; r = 4'b0010;
    tick(); tick();
    chk("pre_conf", 32'(d0_conf), 32'h3);
    chk("pre_cnt",  32'(d0_cnt),  32'h5);
    err_clr = 1'b1; s = 4'b0100; r = 4'b0100;
    tick();
    chk("coll_conf", 32'(d0_conf), 32'h4);
    chk("coll_cnt",  32'(d0_cnt),  32'h1);
    s = 4'h0; r = 4'h0;
    tick();
    chk("post_conf", 32'(d0_conf), 32'h0);
    chk("post_cnt",  32'(d0_cnt),  32'h0);

    // reset mid-sequence
    err_clr = 1'b0; rst_n = 1'b0; s = 4'b0001; r = 4'b0000;
    tick();
    chk("mid_rst_q",    32'(dr_q),    32'hA);
    chk("mid_rst_rise", 32'(dr_rise), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("mid_rel_q",    32'(dr_q),    32'hB);
    chk("mid_rel_rise", 32'(dr_rise), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
